// File: rtl/uart_tx_frame_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop bit.
// Define UART_TX_HOLD_BUF_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_frame_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q;
    logic [5:0]            cnt_q;
    logic [5:0]            presc_q;
    logic [5:0]            presc_d;
    logic [BW-1:0]         bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  busy_d;

    logic                  accept;
    logic                  cnt_last;
    logic                  stop_last;
    logic                  start_frame;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_pe;
    logic                  ld_pt;

    assign presc_d   = (Prescale < 6'd4) ? 6'd4 : Prescale;
    assign cnt_last  = (cnt_q == presc_q - 6'd1);
    assign stop_last = (state_q == STOP) && cnt_last;
    assign accept    = Data_Valid && !busy_q;

`ifdef UART_TX_HOLD_BUF_EN
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_pe_q;
    logic                  hold_pt_q;
    logic                  hold_full_q;
    logic                  start_in;
    logic                  start_hold;
    logic                  hold_fill;

    // A byte offered while the line is free (idle or final stop cycle) skips the buffer
    assign start_in    = accept && ((state_q == IDLE) || (stop_last && !hold_full_q));
    assign start_hold  = stop_last && hold_full_q;
    assign hold_fill   = accept && !start_in;
    assign start_frame = start_in || start_hold;
    assign ld_data     = hold_full_q ? hold_data_q : P_DATA;
    assign ld_pe       = hold_full_q ? hold_pe_q : PAR_EN;
    assign ld_pt       = hold_full_q ? hold_pt_q : PAR_TYP;
    assign busy_d      = hold_fill ? 1'b1 : (start_hold ? 1'b0 : hold_full_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_data_q <= '0;
            hold_pe_q   <= 1'b0;
            hold_pt_q   <= 1'b0;
            hold_full_q <= 1'b0;
        end else if (hold_fill) begin
            hold_data_q <= P_DATA;
            hold_pe_q   <= PAR_EN;
            hold_pt_q   <= PAR_TYP;
            hold_full_q <= 1'b1;
        end else if (start_hold) begin
            hold_full_q <= 1'b0;
        end
    end
`else
    assign start_frame = accept;
    assign ld_data     = P_DATA;
    assign ld_pe       = PAR_EN;
    assign ld_pt       = PAR_TYP;
    assign busy_d      = start_frame ? 1'b1 : (stop_last ? 1'b0 : busy_q);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            presc_q   <= 6'd4;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (state_q != IDLE) begin
                cnt_q <= cnt_last ? 6'd0 : cnt_q + 6'd1;
            end
            unique case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                end
                START: begin
                    if (cnt_last) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        if (bit_q == BIT_LAST) begin
                            state_q <= par_en_q ? PARITY : STOP;
                            tx_q    <= par_en_q ? par_bit_q : 1'b1;
                        end else begin
                            bit_q   <= bit_q + BW'(1);
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (cnt_last) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_last) begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
            // Frame launch overrides whatever the case above chose
            if (start_frame) begin
                state_q   <= START;
                cnt_q     <= '0;
                presc_q   <= presc_d;
                shift_q   <= ld_data;
                par_en_q  <= ld_pe;
                par_bit_q <= ld_pt ? ~^ld_data : ^ld_data;
                tx_q      <= 1'b0;
            end
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Directed bench for uart_tx_frame_serializer: frame shape, parity, clamp,
// busy handling, mid-frame reset and (with UART_TX_HOLD_BUF_EN) back-to-back frames.
module tb_uart_tx_frame_serializer;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef UART_TX_HOLD_BUF_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    uart_tx_frame_serializer #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .TX_OUT    (TX_OUT),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sends one frame and checks TX_OUT/busy on every cycle until idle.
    // At poke_c: Prescale, PAR_EN, PAR_TYP change; optionally a Data_Valid with 0x3C.
    task automatic run_frame(input string nm, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [5:0] ps, input int eff,
                             input logic pbit, input int poke_c, input logic poke_dv,
                             input logic keep_dv);
        logic exp_bits[0:10];
        int   nb;
        int   total;
        nb = 10 + int'(pe);
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
        exp_bits[9]  = pe ? pbit : 1'b1;
        exp_bits[10] = 1'b1;
        total = nb * eff;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = ps;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = keep_dv;
        for (int c = 0; c < total; c++) begin
            check($sformatf("%s_tx_c%0d", nm, c), 32'(TX_OUT), 32'(exp_bits[c/eff]));
            check($sformatf("%s_busy_c%0d", nm, c), 32'(busy), 32'(!HB));
            if (c == poke_c) begin
                Prescale = 6'd32;
                PAR_EN   = !pe;
                PAR_TYP  = !pt;
                if (poke_dv) begin
                    Data_Valid = 1'b1;
                    P_DATA     = 8'h3C;
                end
            end
            if (c == poke_c + 4) Data_Valid = keep_dv;
            tick();
        end
        check($sformatf("%s_end_tx", nm), 32'(TX_OUT), 32'd1);
        check($sformatf("%s_end_busy", nm), 32'(busy), 32'd0);
    endtask

    initial begin
        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd8;
        repeat (3) tick();
        check("rst_tx", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        RST = 1'b0;
        tick();
        check("idle_tx", 32'(TX_OUT), 32'd1);

        run_frame("a5_p8", 8'hA5, 1'b0, 1'b0, 6'd8, 8, 1'b0, -1, 1'b0, 1'b0);
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 6'd16, 16, 1'b0, -1, 1'b0, 1'b0);
        run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 6'd16, 16, 1'b1, -1, 1'b0, 1'b0);
        run_frame("07_odd", 8'h07, 1'b1, 1'b1, 6'd5, 5, 1'b0, -1, 1'b0, 1'b0);
        run_frame("clamp2", 8'h3C, 1'b0, 1'b0, 6'd2, 4, 1'b0, -1, 1'b0, 1'b0);
        run_frame("clamp0", 8'hC3, 1'b1, 1'b0, 6'd0, 4, 1'b0, -1, 1'b0, 1'b0);
        run_frame("ps_chg", 8'h96, 1'b1, 1'b0, 6'd8, 8, 1'b0, 20, 1'b0, 1'b0);
        run_frame("ps63", 8'h01, 1'b0, 1'b0, 6'd63, 63, 1'b0, -1, 1'b0, 1'b0);

        if (!HB) begin
            run_frame("ign3c", 8'h81, 1'b0, 1'b0, 6'd8, 8, 1'b0, 36, 1'b1, 1'b0);
            tick();
            check("ign3c_after", 32'(busy), 32'd0);
            run_frame("gap", 8'hA5, 1'b0, 1'b0, 6'd8, 8, 1'b0, -1, 1'b0, 1'b1);
            tick();
            check("gap_start_tx", 32'(TX_OUT), 32'd0);
            check("gap_start_busy", 32'(busy), 32'd1);
            Data_Valid = 1'b0;
            repeat (80) tick();
            check("gap_done_busy", 32'(busy), 32'd0);
        end

        P_DATA     = 8'h81;
        PAR_EN     = 1'b0;
        Prescale   = 6'd8;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        repeat (34) tick();
        check("rst_mid_bit3", 32'(TX_OUT), 32'd0);
        RST = 1'b1;
        #1;
        check("rst_mid_tx", 32'(TX_OUT), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        tick();
        RST = 1'b0;
        tick();
        check("post_rst_idle", 32'(TX_OUT), 32'd1);
        run_frame("post_rst", 8'h81, 1'b0, 1'b0, 6'd8, 8, 1'b0, -1, 1'b0, 1'b0);

`ifdef UART_TX_HOLD_BUF_EN
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        Prescale   = 6'd8;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        for (int c = 0; c < 160; c++) begin
            logic [7:0] dd;
            logic [9:0] fr;
            dd = (c < 80) ? 8'h55 : 8'hAA;
            fr = {1'b1, dd, 1'b0};
            check($sformatf("hb_tx_c%0d", c), 32'(TX_OUT), 32'(fr[(c % 80) / 8]));
            check($sformatf("hb_busy_c%0d", c), 32'(busy),
                  32'((c >= 11) && (c < 80)));
            if (c == 10) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'hAA;
            end
            if (c == 20) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'hFF;
            end
            if (c == 11 || c == 21) Data_Valid = 1'b0;
            tick();
        end
        check("hb_end_tx", 32'(TX_OUT), 32'd1);
        check("hb_end_busy", 32'(busy), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
